// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path (accumulator and serializer):
// capacity, link terminator bytes and the common 3-bit state encoding.
package uart_cmd_pkg;

  localparam int MAX_BYTES = 128;

  localparam logic [7:0] TERM_BLE = 8'h0D;
  localparam logic [7:0] TERM_HI  = 8'hBE;
  localparam logic [7:0] TERM_LO  = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_TERM0   = 3'd2,
    ST_TERM1   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/uart_cmd_timeout_counter.sv
// Stall watchdog: counts consecutive stalled cycles and flags the cycle on
// which one more stall would reach TIMEOUT.
module uart_cmd_timeout_counter #(
  parameter int TIMEOUT = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // An accept (clr) in the final cycle takes precedence over expiry.
  assign expired = inc && !clr && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_command_serializer.sv
// Streams a latched command buffer to the UART TX core over valid/ready and
// appends the link terminator (0x0D for BLE, 0xBE 0xEF otherwise).
module uart_command_serializer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT = 2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] input_data,
  input  logic [7:0]             input_data_size,
  input  logic                   ble_side,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int IDX_W = $clog2(MAX_BYTES);

  state_e                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [7:0]             size_q, size_d;
  logic                   ble_q, ble_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   error_q, error_d;

  logic accept;
  logic expired;
  logic last_byte;

  assign accept    = tx_valid && tx_ready;
  assign last_byte = (8'(idx_q) == (size_q - 8'd1));

  uart_cmd_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     ((state_q == ST_IDLE) || accept),
    .inc     (tx_valid && !tx_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      size_q  <= '0;
      ble_q   <= 1'b0;
      idx_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      size_q  <= size_d;
      ble_q   <= ble_d;
      idx_q   <= idx_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    size_d  = size_q;
    ble_d   = ble_q;
    idx_d   = idx_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = input_data;
          size_d  = input_data_size;
          ble_d   = ble_side;
          idx_d   = '0;
          error_d = 1'b0;
          if (input_data_size > 8'(MAX_BYTES)) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else if (input_data_size == 8'd0) begin
            state_d = ST_TERM0;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (expired) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (accept) begin
          if (last_byte) begin
            state_d = ST_TERM0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_TERM0: begin
        if (expired) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (accept) begin
          state_d = ble_q ? ST_DONE : ST_TERM1;
        end
      end
      ST_TERM1: begin
        if (expired) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (accept) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state alone so an async reset clears them at once.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = data_q[{idx_q, 3'b000} +: 8];
      end
      ST_TERM0: begin
        tx_valid = 1'b1;
        tx_data  = ble_q ? TERM_BLE : TERM_HI;
      end
      ST_TERM1: begin
        tx_valid = 1'b1;
        tx_data  = TERM_LO;
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign error = error_q;

endmodule

// File: tb/tb_uart_command_serializer.sv
// Self-checking bench: each transfer's expected byte stream is built as a
// queue (payload bytes then terminator) and compared against the TX side.
module tb_uart_command_serializer;

  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1023:0] input_data;
  logic [7:0]    input_data_size;
  logic          ble_side;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;
  logic          error;

  int vectors     = 0;
  int miscompares = 0;

  uart_command_serializer #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .input_data      (input_data),
    .input_data_size (input_data_size),
    .ble_side        (ble_side),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] randomBuffer();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // mode: 0 = always ready, 1 = one stall per byte, 2 = random 0..7 stalls, 3 = 7 stalls
  task automatic applyStimulus(input logic [7:0] size, input logic ble, input int mode,
                               input logic hold_start, input logic [1023:0] buffer);
    logic [7:0] q[$];
    int         stalls;
    for (int i = 0; i < int'(size); i++) q.push_back(buffer[8*i +: 8]);
    if (ble) begin
      q.push_back(8'h0D);
    end else begin
      q.push_back(8'hBE);
      q.push_back(8'hEF);
    end
    input_data      = buffer;
    input_data_size = size;
    ble_side        = ble;
    tx_ready        = 1'b0;
    start           = 1'b1;
    step();
    start           = hold_start;
    input_data      = randomBuffer();
    input_data_size = 8'($urandom_range(1, 128));
    ble_side        = ~ble;
    checkOutput("busy_after_start", busy, 8'd1);
    checkOutput("error_cleared", error, 8'd0);
    while (q.size() > 0) begin
      case (mode)
        0:       stalls = 0;
        1:       stalls = 1;
        2:       stalls = $urandom_range(0, TIMEOUT - 1);
        default: stalls = TIMEOUT - 1;
      endcase
      repeat (stalls) begin
        tx_ready = 1'b0;
        checkOutput("valid_stall", tx_valid, 8'd1);
        checkOutput("data_stall", tx_data, q[0]);
        step();
      end
      tx_ready = 1'b1;
      checkOutput("valid", tx_valid, 8'd1);
      checkOutput("data", tx_data, q[0]);
      step();
      void'(q.pop_front());
    end
    start    = 1'b0;
    tx_ready = 1'b0;
    checkOutput("end_valid", tx_valid, 8'd0);
    checkOutput("end_done", done, 8'd1);
    checkOutput("end_busy", busy, 8'd1);
    checkOutput("end_error", error, 8'd0);
    step();
    checkOutput("idle_done", done, 8'd0);
    checkOutput("idle_busy", busy, 8'd0);
  endtask

  initial begin
    logic [1023:0] buf_r;
    logic [7:0]    sz;
    reset           = 1'b1;
    start           = 1'b0;
    input_data      = '0;
    input_data_size = 8'd0;
    ble_side        = 1'b0;
    tx_ready        = 1'b0;
    #1;
    checkOutput("reset_tx_data", tx_data, 8'd0);
    checkOutput("reset_tx_valid", tx_valid, 8'd0);
    checkOutput("reset_busy", busy, 8'd0);
    checkOutput("reset_done", done, 8'd0);
    checkOutput("reset_error", error, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    $display("[TB] directed: 3-byte BLE frame");
    buf_r = randomBuffer();
    buf_r[23:0] = 24'h434241;
    applyStimulus(8'd3, 1'b1, 0, 1'b0, buf_r);

    $display("[TB] directed: 2-byte frame, toggling ready");
    buf_r = randomBuffer();
    buf_r[15:0] = 16'h0201;
    applyStimulus(8'd2, 1'b0, 1, 1'b1, buf_r);

    $display("[TB] empty payload");
    applyStimulus(8'd0, 1'b0, 2, 1'b0, randomBuffer());

    $display("[TB] oversize request");
    input_data_size = 8'($urandom_range(129, 255));
    input_data      = randomBuffer();
    start           = 1'b1;
    step();
    start = 1'b0;
    checkOutput("over_valid", tx_valid, 8'd0);
    checkOutput("over_done", done, 8'd1);
    checkOutput("over_error", error, 8'd1);
    step();
    checkOutput("over_idle_busy", busy, 8'd0);
    checkOutput("over_idle_valid", tx_valid, 8'd0);
    checkOutput("over_sticky_error", error, 8'd1);

    $display("[TB] full 128-byte payload");
    applyStimulus(8'd128, 1'b1, 0, 1'b0, randomBuffer());

    $display("[TB] maximal stalls just under timeout");
    applyStimulus(8'($urandom_range(1, 6)), 1'($urandom), 3, 1'b0, randomBuffer());

    $display("[TB] randomized transfers");
    for (int t = 0; t < 10; t++) begin
      sz = 8'($urandom_range(0, 128));
      applyStimulus(sz, 1'($urandom), $urandom_range(0, 2), 1'($urandom), randomBuffer());
    end

    $display("[TB] timeout abort");
    buf_r           = randomBuffer();
    input_data      = buf_r;
    input_data_size = 8'($urandom_range(3, 20));
    ble_side        = 1'($urandom);
    start           = 1'b1;
    step();
    start    = 1'b0;
    tx_ready = 1'b1;
    checkOutput("to_byte0", tx_data, buf_r[7:0]);
    step();
    tx_ready = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      checkOutput("to_valid_held", tx_valid, 8'd1);
      checkOutput("to_data_held", tx_data, buf_r[15:8]);
      step();
    end
    checkOutput("to_valid_drop", tx_valid, 8'd0);
    checkOutput("to_error", error, 8'd1);
    checkOutput("to_done", done, 8'd1);
    step();
    checkOutput("to_idle_busy", busy, 8'd0);
    checkOutput("to_sticky_error", error, 8'd1);

    $display("[TB] reset mid-transfer");
    buf_r           = randomBuffer();
    input_data      = buf_r;
    input_data_size = 8'd5;
    ble_side        = 1'b1;
    start           = 1'b1;
    step();
    start    = 1'b0;
    tx_ready = 1'b1;
    step();
    step();
    checkOutput("rst_byte2", tx_data, buf_r[23:16]);
    reset = 1'b1;
    #1;
    checkOutput("rst_tx_data", tx_data, 8'd0);
    checkOutput("rst_tx_valid", tx_valid, 8'd0);
    checkOutput("rst_busy", busy, 8'd0);
    checkOutput("rst_done", done, 8'd0);
    checkOutput("rst_error", error, 8'd0);
    step();
    reset = 1'b0;
    step();
    checkOutput("rst_no_done", done, 8'd0);
    applyStimulus(8'd4, 1'b0, 2, 1'b0, randomBuffer());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
